// File: rtl/seven_seg_scanner.sv
// Multi-digit, time-multiplexed 7-segment driver with active-low segment/anode outputs.
// New digit values are latched into a pending register and only become visible at frame boundaries.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit HEX_MODE    = 1'b0,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRE_NEAR = PW'(REFRESH_DIV - 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           idx;
  logic                    tick;
  logic                    wrap;
  logic                    wrap_soon;
  logic [4*NUM_DIGITS-1:0] pend_digits;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] act_digits;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic                    zero_run;
  logic [3:0]              cur_code;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;
  logic                    dp_next;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    g = 7'b1111111;
    case (code)
      4'd0:  g = 7'b0000001;
      4'd1:  g = 7'b1001111;
      4'd2:  g = 7'b0010010;
      4'd3:  g = 7'b0000110;
      4'd4:  g = 7'b1001100;
      4'd5:  g = 7'b0100100;
      4'd6:  g = HEX_MODE ? 7'b0100000 : 7'b1100000;
      4'd7:  g = 7'b0001111;
      4'd8:  g = 7'b0000000;
      4'd9:  g = 7'b0001100;
      4'd10: g = HEX_MODE ? 7'b0001000 : 7'b1111111;
      4'd11: g = HEX_MODE ? 7'b1100000 : 7'b1111111;
      4'd12: g = HEX_MODE ? 7'b0110001 : 7'b1111111;
      4'd13: g = HEX_MODE ? 7'b1000010 : 7'b1111111;
      4'd14: g = HEX_MODE ? 7'b0110000 : 7'b1111111;
      4'd15: g = HEX_MODE ? 7'b0111000 : 7'b1111111;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  assign tick      = (prescaler == PRE_LAST);
  assign wrap      = tick && (idx == IDX_LAST);
  // frame_done is registered one cycle early so it lands exactly on the wrap cycle
  assign wrap_soon = (prescaler == PRE_NEAR) && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + 1'b1;
      frame_done <= wrap_soon;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // A load on the wrap cycle bypasses pending so the new frame shows it immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
    end else begin
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
      end
      if (wrap) begin
        act_digits <= load ? digits_in : pend_digits;
        act_dp     <= load ? dp_in : pend_dp;
      end
    end
  end

  always_comb begin
    blank_vec = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (act_digits[4*i +: 4] == 4'd0);
      blank_vec[i] = zero_run & (i != 0);
    end
    cur_code = act_digits[{idx, 2'b00} +: 4];
    seg_next = (LZ_BLANK && blank_vec[idx]) ? 7'b1111111 : glyph(cur_code);
    an_next  = '1;
    an_next[idx] = 1'b0;
    dp_next  = ~act_dp[idx];
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      an  <= '1;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: 4 digits, 4-clock refresh, one decimal and one hex instance.
module tb_seven_seg_scanner;

  localparam logic [6:0] G0  = 7'b0000001;
  localparam logic [6:0] G1  = 7'b1001111;
  localparam logic [6:0] G2  = 7'b0010010;
  localparam logic [6:0] G3  = 7'b0000110;
  localparam logic [6:0] G4  = 7'b1001100;
  localparam logic [6:0] G5  = 7'b0100100;
  localparam logic [6:0] G6  = 7'b1100000;
  localparam logic [6:0] G6H = 7'b0100000;
  localparam logic [6:0] GA  = 7'b0001000;
  localparam logic [6:0] GB  = 7'b1100000;
  localparam logic [6:0] GC  = 7'b0110001;
  localparam logic [6:0] GF  = 7'b0111000;
  localparam logic [6:0] BLK = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        enable = 1'b1;
  logic [6:0]  seg, seg_h;
  logic        dp, dp_h;
  logic [3:0]  an, an_h;
  logic        frame_done, frame_done_h;

  int errors = 0;
  int checks = 0;

  logic [6:0] obs_seg [4];
  logic [6:0] obs_seg_h [4];
  logic       obs_dp [4];
  logic [3:0] obs_an [4];

  seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1'b0), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .enable(enable), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1'b1), .LZ_BLANK(1'b1)) dut_h (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .enable(enable), .seg(seg_h), .dp(dp_h), .an(an_h), .frame_done(frame_done_h)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    digits_in = d;
    dp_in = p;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Returns while sitting in the wrap cycle (frame_done high)
  task automatic sync_wrap();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sync_wrap: frame_done=%b after %0d clks, required 1", frame_done, n);
    end
  endtask

  // From the wrap cycle, record the middle of each digit slot of the next frame
  task automatic capture_from_wrap();
    for (int e = 1; e <= 15; e++) begin
      step();
      load = 1'b0;
      if (e % 4 == 3) begin
        obs_seg[e/4]   = seg;
        obs_seg_h[e/4] = seg_h;
        obs_dp[e/4]    = dp;
        obs_an[e/4]    = an;
      end
    end
  endtask

  task automatic capture_frame();
    sync_wrap();
    capture_from_wrap();
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fd;
    int         slot;
    one = 4'b0001;
    reset = 1'b1;
    repeat (3) step();
    checks += 4;
    if (an !== 4'b1111) begin errors++; $display("[TB] FAIL reset_an: got %b expected 1111", an); end
    if (seg !== BLK) begin errors++; $display("[TB] FAIL reset_seg: got %b expected %b", seg, BLK); end
    if (dp !== 1'b1) begin errors++; $display("[TB] FAIL reset_dp: got %b expected 1", dp); end
    if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_fd: got %b expected 0", frame_done); end
    reset = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      step();
      slot    = (n - 1) / 4;
      exp_an  = ~(one << slot);
      exp_seg = (slot == 0) ? G0 : BLK;
      exp_fd  = (n == 15);
      checks += 3;
      if (an !== exp_an) begin errors++; $display("[TB] FAIL scan_an clk%0d: got %b expected %b", n, an, exp_an); end
      if (seg !== exp_seg) begin errors++; $display("[TB] FAIL scan_seg clk%0d: got %b expected %b", n, seg, exp_seg); end
      if (frame_done !== exp_fd) begin errors++; $display("[TB] FAIL scan_fd clk%0d: got %b expected %b", n, frame_done, exp_fd); end
    end
  endtask

  task automatic test_load_midframe();
    logic [6:0] exp_seg [4];
    logic       exp_dp [4];
    logic [3:0] exp_an [4];
    exp_seg = '{G5, G0, G3, BLK};
    exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    pulse_load(16'h0305, 4'b0010);
    repeat (5) step();
    checks += 3;
    if (an !== 4'b1101) begin errors++; $display("[TB] FAIL old_an: got %b expected 1101", an); end
    if (seg !== BLK) begin errors++; $display("[TB] FAIL old_seg: got %b expected %b", seg, BLK); end
    if (dp !== 1'b1) begin errors++; $display("[TB] FAIL old_dp: got %b expected 1", dp); end
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks += 3;
      if (obs_seg[k] !== exp_seg[k]) begin errors++; $display("[TB] FAIL load_seg d%0d: got %b expected %b", k, obs_seg[k], exp_seg[k]); end
      if (obs_dp[k] !== exp_dp[k]) begin errors++; $display("[TB] FAIL load_dp d%0d: got %b expected %b", k, obs_dp[k], exp_dp[k]); end
      if (obs_an[k] !== exp_an[k]) begin errors++; $display("[TB] FAIL load_an d%0d: got %b expected %b", k, obs_an[k], exp_an[k]); end
    end
  endtask

  task automatic test_hex_and_blank();
    logic [6:0] exp_d [4];
    logic [6:0] exp_h [4];
    pulse_load(16'h00A0, 4'b0000);
    capture_frame();
    exp_d = '{G0, BLK, BLK, BLK};
    exp_h = '{G0, GA, BLK, BLK};
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (obs_seg[k] !== exp_d[k]) begin errors++; $display("[TB] FAIL a0_dec d%0d: got %b expected %b", k, obs_seg[k], exp_d[k]); end
      if (obs_seg_h[k] !== exp_h[k]) begin errors++; $display("[TB] FAIL a0_hex d%0d: got %b expected %b", k, obs_seg_h[k], exp_h[k]); end
    end
    pulse_load(16'h6BCF, 4'b0000);
    capture_frame();
    exp_d = '{BLK, BLK, BLK, G6};
    exp_h = '{GF, GC, GB, G6H};
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (obs_seg[k] !== exp_d[k]) begin errors++; $display("[TB] FAIL 6bcf_dec d%0d: got %b expected %b", k, obs_seg[k], exp_d[k]); end
      if (obs_seg_h[k] !== exp_h[k]) begin errors++; $display("[TB] FAIL 6bcf_hex d%0d: got %b expected %b", k, obs_seg_h[k], exp_h[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_seg [4];
    exp_seg = '{G4, G3, G2, G1};
    pulse_load(16'h8888, 4'b1111);
    sync_wrap();
    digits_in = 16'h1234;
    dp_in = 4'b0000;
    load = 1'b1;
    capture_from_wrap();
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (obs_seg[k] !== exp_seg[k]) begin errors++; $display("[TB] FAIL bypass_seg d%0d: got %b expected %b", k, obs_seg[k], exp_seg[k]); end
      if (obs_dp[k] !== 1'b1) begin errors++; $display("[TB] FAIL bypass_dp d%0d: got %b expected 1", k, obs_dp[k]); end
    end
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_seg[k] !== exp_seg[k]) begin errors++; $display("[TB] FAIL pending_seg d%0d: got %b expected %b", k, obs_seg[k], exp_seg[k]); end
    end
  endtask

  task automatic test_enable();
    sync_wrap();
    repeat (6) step();
    enable = 1'b0;
    for (int n = 7; n <= 16; n++) begin
      step();
      checks += 4;
      if (an !== 4'b1111) begin errors++; $display("[TB] FAIL dark_an clk%0d: got %b expected 1111", n, an); end
      if (seg !== BLK) begin errors++; $display("[TB] FAIL dark_seg clk%0d: got %b expected %b", n, seg, BLK); end
      if (dp !== 1'b1) begin errors++; $display("[TB] FAIL dark_dp clk%0d: got %b expected 1", n, dp); end
      if (frame_done !== (n == 16)) begin errors++; $display("[TB] FAIL dark_fd clk%0d: got %b expected %b", n, frame_done, (n == 16)); end
    end
    enable = 1'b1;
    step();
    checks++;
    if (an !== 4'b0111) begin errors++; $display("[TB] FAIL resume_an3: got %b expected 0111", an); end
    step();
    checks += 2;
    if (an !== 4'b1110) begin errors++; $display("[TB] FAIL resume_an0: got %b expected 1110", an); end
    if (seg !== G4) begin errors++; $display("[TB] FAIL resume_seg: got %b expected %b", seg, G4); end
  endtask

  task automatic test_reset_mid();
    int fd_seen;
    sync_wrap();
    repeat (10) step();
    reset = 1'b1;
    step();
    checks += 4;
    if (an !== 4'b1111) begin errors++; $display("[TB] FAIL midrst_an: got %b expected 1111", an); end
    if (seg !== BLK) begin errors++; $display("[TB] FAIL midrst_seg: got %b expected %b", seg, BLK); end
    if (dp !== 1'b1) begin errors++; $display("[TB] FAIL midrst_dp: got %b expected 1", dp); end
    if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_fd: got %b expected 0", frame_done); end
    reset = 1'b0;
    step();
    checks += 2;
    if (an !== 4'b1110) begin errors++; $display("[TB] FAIL postrst_an: got %b expected 1110", an); end
    if (seg !== G0) begin errors++; $display("[TB] FAIL postrst_seg: got %b expected %b", seg, G0); end
    fd_seen = 0;
    for (int n = 13; n <= 25; n++) begin
      step();
      if (frame_done !== 1'b0) fd_seen++;
    end
    checks++;
    if (fd_seen != 0) begin errors++; $display("[TB] FAIL aborted_fd: got %0d pulses expected 0", fd_seen); end
    step();
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL first_fd: got %b expected 1", frame_done); end
    capture_from_wrap();
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (obs_seg[k] !== ((k == 0) ? G0 : BLK)) begin errors++; $display("[TB] FAIL cleared_seg d%0d: got %b expected %b", k, obs_seg[k], ((k == 0) ? G0 : BLK)); end
      if (obs_dp[k] !== 1'b1) begin errors++; $display("[TB] FAIL cleared_dp d%0d: got %b expected 1", k, obs_dp[k]); end
    end
  endtask

  initial begin
    $display("[TB] seven_seg_scanner bench start");
    test_reset();
    test_load_midframe();
    test_hex_and_blank();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
